control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle controller driving the 16-bit processor data path.
- Consumes the fetched instruction word and status flags; produces every data-path control, address and opcode signal.
- Sequences FETCH/DECODE/EXECUTE/WRITEBACK/PC-increment.
- PC increment uses the data-path ALU (PC + 1 through the operand muxes), so no separate incrementer exists.

Parameters:
- PC_W, 16, PC / jump-target width
- RA_W, 5, register/memory address and immediate field width
- OPC_W, 6, ALU opcode width
- ADD_OPC, 6'b000000, ALU opcode used for PC increment and relative branch
- TRAP_VEC, 16'h0010, illegal-opcode target (used only with ILLEGAL_TRAP_EN)

Ports:
- clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- inst  in  16  instruction from inst_mem (valid one cycle after the PC is presented)
- flags_out  in  5  status register: [0]Z [1]C [2]N [3]V [4]P
- opcode  out  6  ALU opcode
- reg_addr1, reg_addr2  out  5 each  register file read ports
- mem_addr  out  5  data memory address
- imd_operand  out  5  immediate to sign extender
- imd_addr  out  16  absolute jump target
- mem_wr, reg_wr, st_reg_ld  out  1 each  write/load enables
- IorR  out  1  1 = sign-extended immediate as operand2, 0 = reg_out_2
- PcorR  out  1  1 = PC as operand1, 0 = reg_out_1
- pc_addr_sel  out  1  1 = imd_addr, 0 = ALU result as PC load value
- Pc_Rst, Pc_Ld  out  1 each  PC clear / load
- Din_Sel  out  2  00 mem, 01 ALU result, 10 temp_storage
- halted  out  1  high in S_HALT

Behaviour:
- Instruction format: op = ir[15:10], A = ir[9:5], B = ir[4:0].
- ir is latched in S_DECODE. All outputs decode combinationally from registered state and ir; no output depends on inst directly.
- States:
  - S_RST: Pc_Rst=1 → S_FETCH.
  - S_FETCH: wait for synchronous inst_mem → S_DECODE.
  - S_DECODE: ir <= inst → S_EXEC.
  - S_EXEC, S_WB, S_PCINC, S_HALT: see below.
- Instruction classes (EXEC action; next state):
  - op 00xxxx ALU reg-reg: reg_addr1=A, reg_addr2=B, IorR=0, PcorR=0, opcode=op, st_reg_ld=1 → S_WB.
  - op 01xxxx ALU reg-imm: reg_addr1=A, imd_operand=B, IorR=1, opcode={2'b00,op[3:0]}, st_reg_ld=1 → S_WB.
  - 100000 LOAD: mem_addr=B → S_WB (Din_Sel=00, reg_addr1=A as write address).
  - 100001 STORE: reg_addr1=A, mem_addr=B, mem_wr=1 → S_PCINC.
  - 100010 MOVT: → S_WB with Din_Sel=10.
  - 110000 JMP: imd_addr={6'b0,ir[9:0]}, pc_addr_sel=1, Pc_Ld=1 → S_FETCH.
  - 110001 JZ / 110010 JC: if flags_out[0] / flags_out[1] set, act as JMP; else → S_PCINC.
  - 110011 BRREL: PcorR=1, IorR=1, imd_operand=B, opcode=ADD_OPC, pc_addr_sel=0, Pc_Ld=1 → S_FETCH.
  - 111111 HALT: → S_HALT.
  - All other opcodes: NOP → S_PCINC.
- S_WB: EXEC operand/opcode drives held, st_reg_ld=0, reg_wr=1, Din_Sel per class (ALU 01) → S_PCINC.
- S_PCINC: PcorR=1, IorR=1, imd_operand=5'd1, opcode=ADD_OPC, pc_addr_sel=0, Pc_Ld=1, st_reg_ld=0 → S_FETCH.
- S_HALT: all enables 0, halted=1. Exit only by reset.
- Cycle counts per instruction:
  - ALU/LOAD/MOVT: 5.
  - STORE, not-taken branch, NOP: 4.
  - Taken JMP/JZ/JC/BRREL: 3.
- Flags are sampled in S_EXEC; the previous instruction's st_reg_ld has already committed.
- Outside the listed cases every enable is 0, Din_Sel=00, and all address/opcode outputs are 0.
- Reset:
  - Rst low from any state forces S_RST and ir=0 immediately (asynchronous).
  - While in S_RST: Pc_Rst=1; all enables and halted are 0; every other output is 0.
  - A write enable active at reset assertion drops in the same instant, so no partial write commits on a clock edge.
- PC wrap: FFFF+1 wraps to 0000 (ALU width); no special handling.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an undefined opcode in S_EXEC drives imd_addr=TRAP_VEC, pc_addr_sel=1, Pc_Ld=1 → S_FETCH. No register, memory or flag write occurs.
- Not defined: undefined opcodes are NOP (→ S_PCINC).

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants and class masks
  - state encoding (3-bit)
  - flag bit indices
  - Din_Sel encodings
  - ADD_OPC
- One sub-module, inst_decoder: combinational ir → class one-hot plus field extraction.
- The FSM and output decode stay in control_unit.

Test Plan:
- Reset release with inst=16'h0000 → S_RST Pc_Rst=1 for one cycle; first S_PCINC Pc_Ld=1 at cycle 5; reg_wr pulsed once, in S_WB.
- ADD reg-imm, ir=16'b010000_00011_00101 → EXEC: IorR=1, reg_addr1=3, imd_operand=5, opcode=000000, st_reg_ld=1; next cycle reg_wr=1, Din_Sel=01.
- STORE ir=16'b100001_00010_01111 → mem_wr=1 for exactly one cycle with mem_addr=15, reg_addr1=2; reg_wr never asserted.
- JZ ir=16'hC40A:
  - flags_out=5'b00001 → Pc_Ld=1, pc_addr_sel=1, imd_addr=16'h000A, back in FETCH after 3 cycles.
  - flags_out=0 → S_PCINC path.
- HALT 16'hFC00 → halted=1 held for 20 cycles with all enables 0; Rst pulse low → halted=0 and Pc_Rst=1 asynchronously.
- Opcode 6'b101010: with ILLEGAL_TRAP_EN → imd_addr=16'h0010, Pc_Ld=1; without → S_PCINC increment only.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle controller: widths, opcodes, FSM states,
// flag bit positions, write-back source selects and the instruction-class vector.
package cpu_pkg;

    localparam int PC_W  = 16;
    localparam int RA_W  = 5;
    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] ADD_OPC  = 6'b000000;
    localparam logic [PC_W-1:0]  TRAP_VEC = 16'h0010;

    // Class masks on op[5:4]; the low four bits select the ALU operation.
    localparam logic [1:0] CLS_ALU_RR = 2'b00;
    localparam logic [1:0] CLS_ALU_RI = 2'b01;

    localparam logic [OPC_W-1:0] OP_LOAD  = 6'b100000;
    localparam logic [OPC_W-1:0] OP_STORE = 6'b100001;
    localparam logic [OPC_W-1:0] OP_MOVT  = 6'b100010;
    localparam logic [OPC_W-1:0] OP_JMP   = 6'b110000;
    localparam logic [OPC_W-1:0] OP_JZ    = 6'b110001;
    localparam logic [OPC_W-1:0] OP_JC    = 6'b110010;
    localparam logic [OPC_W-1:0] OP_BRREL = 6'b110011;
    localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_P = 4;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_PCINC  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DIN_MEM  = 2'b00,
        DIN_ALU  = 2'b01,
        DIN_TEMP = 2'b10
    } din_sel_t;

    typedef struct packed {
        logic alu_rr;
        logic alu_ri;
        logic load;
        logic store;
        logic movt;
        logic jmp;
        logic jz;
        logic jc;
        logic brrel;
        logic halt;
        logic undef;
    } inst_class_t;

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> data-path bundle: instruction and flags in, all controls out.
interface control_unit_if;

    logic [cpu_pkg::PC_W-1:0]  inst;
    logic [4:0]                flags_out;
    logic [cpu_pkg::OPC_W-1:0] opcode;
    logic [cpu_pkg::RA_W-1:0]  reg_addr1;
    logic [cpu_pkg::RA_W-1:0]  reg_addr2;
    logic [cpu_pkg::RA_W-1:0]  mem_addr;
    logic [cpu_pkg::RA_W-1:0]  imd_operand;
    logic [cpu_pkg::PC_W-1:0]  imd_addr;
    logic                      mem_wr;
    logic                      reg_wr;
    logic                      st_reg_ld;
    logic                      IorR;
    logic                      PcorR;
    logic                      pc_addr_sel;
    logic                      Pc_Rst;
    logic                      Pc_Ld;
    logic [1:0]                Din_Sel;
    logic                      halted;

    modport master (
        input  inst, flags_out,
        output opcode, reg_addr1, reg_addr2, mem_addr, imd_operand, imd_addr,
               mem_wr, reg_wr, st_reg_ld, IorR, PcorR, pc_addr_sel,
               Pc_Rst, Pc_Ld, Din_Sel, halted
    );

    modport slave (
        output inst, flags_out,
        input  opcode, reg_addr1, reg_addr2, mem_addr, imd_operand, imd_addr,
               mem_wr, reg_wr, st_reg_ld, IorR, PcorR, pc_addr_sel,
               Pc_Rst, Pc_Ld, Din_Sel, halted
    );

endinterface

// File: rtl/inst_decoder.sv
// Combinational instruction decode: one-hot class vector plus op/A/B fields
// and the zero-extended absolute jump target.
module inst_decoder
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]  ir,
    output inst_class_t      cls,
    output logic [OPC_W-1:0] op,
    output logic [RA_W-1:0]  a,
    output logic [RA_W-1:0]  b,
    output logic [PC_W-1:0]  jmp_target
);

    assign op         = ir[15:10];
    assign a          = ir[9:5];
    assign b          = ir[4:0];
    assign jmp_target = {{(PC_W-10){1'b0}}, ir[9:0]};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        cls = '0;
        if (op[5:4] == CLS_ALU_RR) begin
            cls.alu_rr = 1'b1;
        end else if (op[5:4] == CLS_ALU_RI) begin
            cls.alu_ri = 1'b1;
        end else begin
            case (op)
                OP_LOAD:  cls.load  = 1'b1;
                OP_STORE: cls.store = 1'b1;
                OP_MOVT:  cls.movt  = 1'b1;
                OP_JMP:   cls.jmp   = 1'b1;
                OP_JZ:    cls.jz    = 1'b1;
                OP_JC:    cls.jc    = 1'b1;
                OP_BRREL: cls.brrel = 1'b1;
                OP_HALT:  cls.halt  = 1'b1;
                default:  cls.undef = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FSM sequencing FETCH/DECODE/EXEC/WB/PCINC for the 16-bit data path.
// Build option: define ILLEGAL_TRAP_EN to vector undefined opcodes to TRAP_VEC.
module control_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           Rst,
    control_unit_if.master bus
);

    state_t           state;
    state_t           state_nx;
    logic [PC_W-1:0]  ir;
    inst_class_t      cls;
    logic [OPC_W-1:0] op;
    logic [RA_W-1:0]  fld_a;
    logic [RA_W-1:0]  fld_b;
    logic [PC_W-1:0]  jmp_target;
    logic             jump_taken;

    inst_decoder u_dec (
        .ir         (ir),
        .cls        (cls),
        .op         (op),
        .a          (fld_a),
        .b          (fld_b),
        .jmp_target (jmp_target)
    );

    // Flags from the previous instruction have already committed by S_EXEC.
    assign jump_taken = (cls.jz && bus.flags_out[FLAG_Z]) ||
                        (cls.jc && bus.flags_out[FLAG_C]);

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_RST;
            ir    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nx;
            if (state == S_DECODE) begin
                ir <= bus.inst;
            end
        end
    end

    always_comb begin
        bus.opcode      = '0;
        bus.reg_addr1   = '0;
        bus.reg_addr2   = '0;
        bus.mem_addr    = '0;
        bus.imd_operand = '0;
        bus.imd_addr    = '0;
        bus.mem_wr      = 1'b0;
        bus.reg_wr      = 1'b0;
        bus.st_reg_ld   = 1'b0;
        bus.IorR        = 1'b0;
        bus.PcorR       = 1'b0;
        bus.pc_addr_sel = 1'b0;
        bus.Pc_Rst      = 1'b0;
        bus.Pc_Ld       = 1'b0;
        bus.Din_Sel     = DIN_MEM;
        bus.halted      = 1'b0;
        state_nx        = state;

        case (state)
            S_RST: begin
                bus.Pc_Rst = 1'b1;
                state_nx   = S_FETCH;
            end
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC, S_WB: begin
                // Operand drives are shared so S_WB holds what S_EXEC presented.
                if (cls.alu_rr) begin
                    bus.reg_addr1 = fld_a;
                    bus.reg_addr2 = fld_b;
                    bus.opcode    = op;
                end
                if (cls.alu_ri) begin
                    bus.reg_addr1   = fld_a;
                    bus.imd_operand = fld_b;
                    bus.IorR        = 1'b1;
                    bus.opcode      = {2'b00, op[3:0]};
                end
                if (cls.load) begin
                    bus.reg_addr1 = fld_a;
                    bus.mem_addr  = fld_b;
                end
                if (cls.movt) begin
                    bus.reg_addr1 = fld_a;
                end

                if (state == S_WB) begin
                    bus.reg_wr = 1'b1;
                    if (cls.movt)      bus.Din_Sel = DIN_TEMP;
                    else if (cls.load) bus.Din_Sel = DIN_MEM;
                    else               bus.Din_Sel = DIN_ALU;
                    state_nx = S_PCINC;
                end else if (cls.alu_rr || cls.alu_ri) begin
                    bus.st_reg_ld = 1'b1;
                    state_nx      = S_WB;
                end else if (cls.load || cls.movt) begin
                    state_nx = S_WB;
                end else if (cls.store) begin
                    bus.reg_addr1 = fld_a;
                    bus.mem_addr  = fld_b;
                    bus.mem_wr    = 1'b1;
                    state_nx      = S_PCINC;
                end else if (cls.jmp || jump_taken) begin
                    bus.imd_addr    = jmp_target;
                    bus.pc_addr_sel = 1'b1;
                    bus.Pc_Ld       = 1'b1;
                    state_nx        = S_FETCH;
                end else if (cls.brrel) begin
                    bus.PcorR       = 1'b1;
                    bus.IorR        = 1'b1;
                    bus.imd_operand = fld_b;
                    bus.opcode      = ADD_OPC;
                    bus.Pc_Ld       = 1'b1;
                    state_nx        = S_FETCH;
                end else if (cls.halt) begin
                    state_nx = S_HALT;
                end else if (cls.undef) begin
`ifdef ILLEGAL_TRAP_EN
                    bus.imd_addr    = TRAP_VEC;
                    bus.pc_addr_sel = 1'b1;
                    bus.Pc_Ld       = 1'b1;
                    state_nx        = S_FETCH;
`else
                    state_nx = S_PCINC;
`endif
                end else begin
                    state_nx = S_PCINC;
                end
            end
            S_PCINC: begin
                bus.PcorR       = 1'b1;
                bus.IorR        = 1'b1;
                bus.imd_operand = 5'd1;
                bus.opcode      = ADD_OPC;
                bus.Pc_Ld       = 1'b1;
                state_nx        = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                state_nx   = S_HALT;
            end
            default: state_nx = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: per-instruction cycle-list model checked every cycle,
// directed cases from the plan, then randomized instruction streams.
module tb_control_unit;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  reg_addr1;
        logic [4:0]  reg_addr2;
        logic [4:0]  mem_addr;
        logic [4:0]  imd_operand;
        logic [15:0] imd_addr;
        logic        mem_wr;
        logic        reg_wr;
        logic        st_reg_ld;
        logic        IorR;
        logic        PcorR;
        logic        pc_addr_sel;
        logic        Pc_Rst;
        logic        Pc_Ld;
        logic [1:0]  Din_Sel;
        logic        halted;
    } out_t;

    localparam logic [5:0] T_LOAD = 6'b100000, T_STORE = 6'b100001, T_MOVT = 6'b100010;
    localparam logic [5:0] T_JMP = 6'b110000, T_JZ = 6'b110001, T_JC = 6'b110010;
    localparam logic [5:0] T_BRREL = 6'b110011, T_HALT = 6'b111111;
    localparam int HALT_CYCLES = 20;

    logic clk;
    logic Rst;
    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];
    out_t hist[$];

    function automatic out_t snap();
        out_t s;
        s.opcode      = bus.opcode;
        s.reg_addr1   = bus.reg_addr1;
        s.reg_addr2   = bus.reg_addr2;
        s.mem_addr    = bus.mem_addr;
        s.imd_operand = bus.imd_operand;
        s.imd_addr    = bus.imd_addr;
        s.mem_wr      = bus.mem_wr;
        s.reg_wr      = bus.reg_wr;
        s.st_reg_ld   = bus.st_reg_ld;
        s.IorR        = bus.IorR;
        s.PcorR       = bus.PcorR;
        s.pc_addr_sel = bus.pc_addr_sel;
        s.Pc_Rst      = bus.Pc_Rst;
        s.Pc_Ld       = bus.Pc_Ld;
        s.Din_Sel     = bus.Din_Sel;
        s.halted      = bus.halted;
        return s;
    endfunction

    function automatic out_t pcinc_v();
        out_t v = '0;
        v.PcorR = 1'b1; v.IorR = 1'b1; v.imd_operand = 5'd1; v.Pc_Ld = 1'b1;
        return v;
    endfunction

    function automatic out_t rst_v();
        out_t v = '0;
        v.Pc_Rst = 1'b1;
        return v;
    endfunction

    // Expected per-cycle outputs of one instruction, starting at its FETCH cycle.
    function automatic void build(input logic [15:0] w, input logic [4:0] f);
        logic [5:0] op = w[15:10];
        logic [4:0] a  = w[9:5];
        logic [4:0] b  = w[4:0];
        out_t ex = '0;
        out_t wb;
        logic jump;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        jump = (op == T_JMP) || (op == T_JZ && f[0]) || (op == T_JC && f[1]);
        if (op[5:4] == 2'b00 || op[5:4] == 2'b01) begin
            ex.reg_addr1 = a;
            if (op[4]) begin
                ex.imd_operand = b; ex.IorR = 1'b1; ex.opcode = {2'b00, op[3:0]};
            end else begin
                ex.reg_addr2 = b; ex.opcode = op;
            end
            ex.st_reg_ld = 1'b1;
            wb = ex; wb.st_reg_ld = 1'b0; wb.reg_wr = 1'b1; wb.Din_Sel = 2'b01;
            exp_q.push_back(ex); exp_q.push_back(wb); exp_q.push_back(pcinc_v());
        end else if (op == T_LOAD || op == T_MOVT) begin
            ex.reg_addr1 = a;
            if (op == T_LOAD) ex.mem_addr = b;
            wb = ex; wb.reg_wr = 1'b1; wb.Din_Sel = (op == T_MOVT) ? 2'b10 : 2'b00;
            exp_q.push_back(ex); exp_q.push_back(wb); exp_q.push_back(pcinc_v());
        end else if (op == T_STORE) begin
            ex.reg_addr1 = a; ex.mem_addr = b; ex.mem_wr = 1'b1;
            exp_q.push_back(ex); exp_q.push_back(pcinc_v());
        end else if (jump) begin
            ex.imd_addr = {6'b0, w[9:0]}; ex.pc_addr_sel = 1'b1; ex.Pc_Ld = 1'b1;
            exp_q.push_back(ex);
        end else if (op == T_JZ || op == T_JC) begin
            exp_q.push_back(ex); exp_q.push_back(pcinc_v());
        end else if (op == T_BRREL) begin
            ex.PcorR = 1'b1; ex.IorR = 1'b1; ex.imd_operand = b; ex.Pc_Ld = 1'b1;
            exp_q.push_back(ex);
        end else if (op == T_HALT) begin
            exp_q.push_back(ex);
            for (int i = 0; i < HALT_CYCLES; i++) begin
                out_t h = '0;
                h.halted = 1'b1;
                exp_q.push_back(h);
            end
        end else begin
`ifdef ILLEGAL_TRAP_EN
            ex.imd_addr = 16'h0010; ex.pc_addr_sel = 1'b1; ex.Pc_Ld = 1'b1;
            exp_q.push_back(ex);
`else
            exp_q.push_back(ex); exp_q.push_back(pcinc_v());
`endif
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic compare(input out_t e, input string name);
        out_t got = snap();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, required %h", name, $time, got, e);
        end
    endtask

    // Called at posedge+1; compares at the negedge, returns at the next posedge+1.
    task automatic step(input out_t e, input string name);
        @(negedge clk);
        compare(e, name);
        hist.push_back(snap());
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        Rst = 1'b0;
        #1;
        compare(rst_v(), "rst_async");
    endtask

    task automatic finish_reset();
        @(posedge clk);
        #1;
        step(rst_v(), "rst_hold");
        Rst = 1'b1;
        step(rst_v(), "rst_release");
    endtask

    task automatic run_inst(input logic [15:0] w, input logic [4:0] f, input string name);
        bus.inst      = w;
        bus.flags_out = f;
        build(w, f);
        hist.delete();
        while (exp_q.size() > 0) step(exp_q.pop_front(), name);
    endtask

    function automatic int count_reg_wr();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i].reg_wr);
        return n;
    endfunction

    function automatic int count_mem_wr();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i].mem_wr);
        return n;
    endfunction

    function automatic int count_halted();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i].halted);
        return n;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Rst           = 1'b0;
        bus.inst      = 16'h0000;
        bus.flags_out = 5'b0;
        @(posedge clk);
        #1;
        assert_reset();
        check("rst_pc_rst", 32'(bus.Pc_Rst), 32'd1);
        finish_reset();

        // inst = 0 is an ALU reg-reg add: PC increment in the fifth cycle.
        run_inst(16'h0000, 5'b0, "alu_zero");
        check("zero_pcinc_ld", 32'(hist[4].Pc_Ld), 32'd1);
        check("zero_wb_reg_wr", 32'(hist[3].reg_wr), 32'd1);
        check("zero_reg_wr_count", 32'(count_reg_wr()), 32'd1);

        run_inst(16'h4065, 5'b0, "add_imm");
        check("addi_iorr", 32'(hist[2].IorR), 32'd1);
        check("addi_ra1", 32'(hist[2].reg_addr1), 32'd3);
        check("addi_imd", 32'(hist[2].imd_operand), 32'd5);
        check("addi_opcode", 32'(hist[2].opcode), 32'd0);
        check("addi_st_ld", 32'(hist[2].st_reg_ld), 32'd1);
        check("addi_wb", {hist[3].Din_Sel, 1'b0, hist[3].reg_wr}, 32'b01_0_1);

        run_inst(16'h844F, 5'b0, "store");
        check("store_mem_wr_count", 32'(count_mem_wr()), 32'd1);
        check("store_mem_addr", 32'(hist[2].mem_addr), 32'd15);
        check("store_ra1", 32'(hist[2].reg_addr1), 32'd2);
        check("store_no_reg_wr", 32'(count_reg_wr()), 32'd0);

        run_inst(16'hC40A, 5'b00001, "jz_taken");
        check("jz_t_ld", {hist[2].Pc_Ld, hist[2].pc_addr_sel}, 32'b11);
        check("jz_t_addr", 32'(hist[2].imd_addr), 32'h000A);
        run_inst(16'hC40A, 5'b00000, "jz_not_taken");
        check("jz_nt_exec_ld", 32'(hist[2].Pc_Ld), 32'd0);
        check("jz_nt_pcinc", 32'(hist[3].imd_operand), 32'd1);

        run_inst(16'hA800, 5'b0, "undef");
`ifdef ILLEGAL_TRAP_EN
        check("undef_trap_addr", 32'(hist[2].imd_addr), 32'h0010);
        check("undef_trap_ld", 32'(hist[2].Pc_Ld), 32'd1);
`else
        check("undef_nop_exec", 32'(hist[2]), 32'd0);
        check("undef_pcinc_ld", 32'(hist[3].Pc_Ld), 32'd1);
`endif

        run_inst(16'hFC00, 5'b0, "halt");
        check("halt_cycles", 32'(count_halted()), 32'(HALT_CYCLES));
        #2;
        assert_reset();
        check("halt_rst_halted", 32'(bus.halted), 32'd0);
        check("halt_rst_pc_rst", 32'(bus.Pc_Rst), 32'd1);
        finish_reset();

        // Reset asserted mid-cycle during a store must drop mem_wr at once.
        bus.inst = 16'h844F;
        build(16'h844F, 5'b0);
        step(exp_q.pop_front(), "store_rst_fetch");
        step(exp_q.pop_front(), "store_rst_decode");
        #2;
        check("store_rst_pre", 32'(bus.mem_wr), 32'd1);
        assert_reset();
        check("store_rst_drop", 32'(bus.mem_wr), 32'd0);
        finish_reset();

        for (int n = 0; n < 300; n++) begin
            logic [5:0]  op;
            logic [15:0] rnd = 16'($urandom);
            logic [3:0]  lo  = 4'($urandom);
            case ($urandom_range(0, 9))
                0: op = {2'b00, lo};
                1: op = {2'b01, lo};
                2: op = T_LOAD;
                3: op = T_STORE;
                4: op = T_MOVT;
                5: op = T_JMP;
                6: op = ($urandom_range(0, 1) == 0) ? T_JZ : T_JC;
                7: op = T_BRREL;
                8: op = 6'($urandom);
                default: op = ($urandom_range(0, 9) == 0) ? T_HALT : {2'b10, lo};
            endcase
            run_inst({op, rnd[9:0]}, 5'($urandom), "random");
            if (op == T_HALT) begin
                assert_reset();
                finish_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
